// File: rtl/onchip_mem_reader.sv
// Avalon-MM burst-less reader: fetches `length` consecutive 32-bit words
// starting at `base_addr` and streams them out on an Avalon-ST source.
// Reads are only issued when a buffer slot is guaranteed for the response,
// so the output FIFO can never overflow regardless of sink backpressure.
module onchip_mem_reader #(
  parameter int ADDR_W     = 12,
  parameter int FIFO_DEPTH = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [10:0]       length,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] avm_address,
  output logic              avm_read,
  input  logic              avm_waitrequest,
  input  logic [31:0]       avm_readdata,
  input  logic              avm_readdatavalid,
  output logic [31:0]       st_data,
  output logic              st_valid,
  input  logic              st_ready,
  output logic              st_sop,
  output logic              st_eop
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;

  state_t            state, state_nx;
  logic [ADDR_W-1:0] addr;
  logic [10:0]       len_r;
  logic [10:0]       req_left;
  logic [10:0]       word_idx;
  logic [CW-1:0]     outstanding;
  logic [CW-1:0]     fifo_count;
  logic [PW-1:0]     wr_ptr, rd_ptr;
  logic [31:0]       mem [FIFO_DEPTH];
  logic [CW:0]       credit;
  logic              start_go, start_zero;
  logic              req_acc, rsp_wr, st_xfer, eop_xfer;

  // Slots already claimed: words sitting in the FIFO plus reads still in flight.
  assign credit     = {1'b0, fifo_count} + {1'b0, outstanding};
  assign start_go   = (state == IDLE) && start && (length != 11'd0);
  assign start_zero = (state == IDLE) && start && (length == 11'd0);
  assign req_acc    = avm_read && !avm_waitrequest;
  // Stray responses (idle, or left over from a transfer aborted by reset) are dropped.
  assign rsp_wr     = avm_readdatavalid && (state != IDLE) && (outstanding != '0);
  assign st_valid   = (fifo_count != '0);
  assign st_xfer    = st_valid && st_ready;
  assign st_sop     = st_valid && (word_idx == 11'd0);
  assign st_eop     = st_valid && (word_idx == len_r - 11'd1);
  assign eop_xfer   = st_xfer && st_eop;
  assign st_data    = st_valid ? mem[rd_ptr] : 32'd0;
  assign avm_address = addr;
  assign busy       = (state != IDLE);

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nx;
  end

  // Next-state and read-request decode. The request stays up under
  // waitrequest because credit can only shrink until the request is taken.
  always_comb begin
    state_nx = state;
    avm_read = 1'b0;
    case (state)
      IDLE: begin
        if (start_go) state_nx = ISSUE;
      end
      ISSUE: begin
        avm_read = (credit < (CW+1)'(FIFO_DEPTH));
        if (avm_read && !avm_waitrequest && (req_left == 11'd1)) state_nx = DRAIN;
      end
      DRAIN: begin
        if (eop_xfer) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Transfer bookkeeping: request address, words left to request, output word index.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      addr     <= '0;
      len_r    <= '0;
      req_left <= '0;
      word_idx <= '0;
    end else if (start_go) begin
      addr     <= base_addr & ~ADDR_W'(3);
      len_r    <= length;
      req_left <= length;
      word_idx <= '0;
    end else begin
      if (req_acc) begin
        addr     <= addr + ADDR_W'(4);
        req_left <= req_left - 11'd1;
      end
      if (st_xfer) word_idx <= word_idx + 11'd1;
    end
  end

  // Reads in flight; simultaneous issue and return cancel out.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) outstanding <= '0;
    else begin
      case ({req_acc, rsp_wr})
        2'b10:   outstanding <= outstanding + CW'(1);
        2'b01:   outstanding <= outstanding - CW'(1);
        default: outstanding <= outstanding;
      endcase
    end
  end

  // FIFO pointers and occupancy; a write and read in the same cycle keep the count.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (rsp_wr)  wr_ptr <= wr_ptr + PW'(1);
      if (st_xfer) rd_ptr <= rd_ptr + PW'(1);
      case ({rsp_wr, st_xfer})
        2'b10:   fifo_count <= fifo_count + CW'(1);
        2'b01:   fifo_count <= fifo_count - CW'(1);
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  // FIFO storage; contents are invisible whenever the count is zero.
  always_ff @(posedge clk) begin
    if (rsp_wr) mem[wr_ptr] <= avm_readdata;
  end

  // Completion pulse: last word handed off, or an empty transfer requested.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) done <= 1'b0;
    else          done <= start_zero || eop_xfer;
  end

endmodule

// File: tb/tb_onchip_mem_reader.sv
// Bench for onchip_mem_reader: a memory-backed Avalon-MM slave with random
// latency/stalls and a random-ready sink log what the DUT does; each test
// compares the logs with the stream expected from the memory contents.
module tb_onchip_mem_reader;
  localparam int ADDR_W = 12;
  localparam int DEPTH  = 8;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic [11:0] base_addr = '0;
  logic [10:0] length = '0;
  logic        busy, done, avm_read, st_valid, st_sop, st_eop;
  logic [11:0] avm_address;
  logic [31:0] st_data;
  logic        avm_waitrequest = 1'b0;
  logic [31:0] avm_readdata = '0;
  logic        avm_readdatavalid = 1'b0;
  logic        st_ready = 1'b0;

  onchip_mem_reader #(.ADDR_W(ADDR_W), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .base_addr(base_addr),
    .length(length), .busy(busy), .done(done), .avm_address(avm_address),
    .avm_read(avm_read), .avm_waitrequest(avm_waitrequest),
    .avm_readdata(avm_readdata), .avm_readdatavalid(avm_readdatavalid),
    .st_data(st_data), .st_valid(st_valid), .st_ready(st_ready),
    .st_sop(st_sop), .st_eop(st_eop)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] mem_model [1024];
  typedef struct { int due; logic [31:0] data; } rsp_t;
  rsp_t        rq[$];
  logic [11:0] addr_log[$];
  int          acc_cyc[$];
  logic [33:0] data_log[$];
  logic [11:0] stall_log[$];
  int cyc = 0, last_due = 0, done_cnt = 0, busy_cnt = 0, busy_at_done = 0;
  int max_credit = 0, read_cnt = 0;
  int lat_min = 1, lat_max = 1, wait_pct = 0, ready_pct = 100;
  int stall_idx = -1, stall_left = 0;
  bit force_ready0 = 1'b0, inject_rdv = 1'b0;

  // Slave + sink environment, acting on every falling edge.
  initial begin
    bit   wr, rdy;
    int   credit, due;
    rsp_t r;
    forever begin
      @(negedge clk);
      cyc++;
      if (done) begin done_cnt++; if (busy) busy_at_done++; end
      if (busy) busy_cnt++;
      if (avm_read) read_cnt++;
      wr = 1'b0;
      if (avm_read) begin
        if (stall_left > 0 && addr_log.size() == stall_idx) begin
          wr = 1'b1;
          stall_log.push_back(avm_address);
          stall_left--;
        end else begin
          wr = (int'($urandom_range(99)) < wait_pct);
        end
      end
      avm_waitrequest = wr;
      if (avm_read && !wr) begin
        credit = addr_log.size() - data_log.size() + 1;
        if (credit > max_credit) max_credit = credit;
        addr_log.push_back(avm_address);
        acc_cyc.push_back(cyc);
        due = cyc + int'($urandom_range(lat_max, lat_min));
        if (due <= last_due) due = last_due + 1;
        last_due = due;
        r.due = due;
        r.data = mem_model[avm_address[11:2]];
        rq.push_back(r);
      end
      if (inject_rdv) begin
        avm_readdatavalid = 1'b1;
        avm_readdata = 32'hDEAD_BEEF;
        inject_rdv = 1'b0;
      end else if (rq.size() > 0 && rq[0].due <= cyc) begin
        r = rq.pop_front();
        avm_readdatavalid = 1'b1;
        avm_readdata = r.data;
      end else begin
        avm_readdatavalid = 1'b0;
        avm_readdata = $urandom;
      end
      rdy = !force_ready0 && (int'($urandom_range(99)) < ready_pct);
      st_ready = rdy;
      if (st_valid && rdy) data_log.push_back({st_sop, st_eop, st_data});
    end
  end

  // Reference: word-aligned address of word i, wrapping in 12 bits.
  function automatic logic [11:0] exp_addr(input logic [11:0] b, input int i);
    return (b & 12'hFFC) + 12'(4 * i);
  endfunction

  // Reference: {sop, eop, data} of word i in a transfer of len words.
  function automatic logic [33:0] exp_word(input logic [11:0] b, input int len, input int i);
    logic [11:0] a;
    a = exp_addr(b, i);
    return {(i == 0), (i == len - 1), mem_model[a[11:2]]};
  endfunction

  task automatic tick(input int n);
    repeat (n) begin @(negedge clk); #1; end
  endtask

  task automatic clear_logs();
    addr_log.delete(); acc_cyc.delete(); data_log.delete(); stall_log.delete(); rq.delete();
    done_cnt = 0; busy_cnt = 0; busy_at_done = 0; max_credit = 0; read_cnt = 0;
    last_due = cyc;
  endtask

  task automatic pulse_start(input logic [11:0] b, input logic [10:0] l);
    start = 1'b1; base_addr = b; length = l;
    tick(1);
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      tick(1);
      if (done_cnt > 0) begin ok = 1'b1; break; end
    end
    tick(3);
  endtask

  task automatic test_reset();
    tick(3);
    n_checks++;
    if ({busy, done, avm_read, st_valid, st_sop, st_eop} !== 6'b0) begin
      n_fail++; $display("FAIL reset_ctrl: got %b want 000000", {busy, done, avm_read, st_valid, st_sop, st_eop});
    end
    n_checks++;
    if (avm_address !== 12'h000 || st_data !== 32'h0) begin
      n_fail++; $display("FAIL reset_data: addr %h data %h want 0/0", avm_address, st_data);
    end
    reset_n = 1'b1;
    tick(3);
    n_checks++;
    if ({busy, done, avm_read, st_valid} !== 4'b0) begin
      n_fail++; $display("FAIL reset_idle: got %b want 0000", {busy, done, avm_read, st_valid});
    end
  endtask

  task automatic test_basic();
    bit ok;
    lat_min = 1; lat_max = 1; wait_pct = 0; ready_pct = 100;
    clear_logs();
    pulse_start(12'h010, 11'd4);
    n_checks++;
    if (busy !== 1'b1) begin n_fail++; $display("FAIL basic_busy: got %b want 1", busy); end
    wait_done(100, ok);
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL basic_timeout: done_cnt %0d want 1", done_cnt); end
    n_checks++;
    if (addr_log.size() != 4 || data_log.size() != 4) begin
      n_fail++; $display("FAIL basic_count: reqs %0d words %0d want 4/4", addr_log.size(), data_log.size());
    end
    for (int i = 0; i < addr_log.size(); i++) begin
      n_checks++;
      if (addr_log[i] !== exp_addr(12'h010, i) || acc_cyc[i] - acc_cyc[0] != i) begin
        n_fail++; $display("FAIL basic_addr[%0d]: got %h at +%0d want %h at +%0d", i, addr_log[i], acc_cyc[i] - acc_cyc[0], exp_addr(12'h010, i), i);
      end
    end
    for (int i = 0; i < data_log.size(); i++) begin
      n_checks++;
      if (data_log[i] !== exp_word(12'h010, 4, i)) begin
        n_fail++; $display("FAIL basic_word[%0d]: got %h want %h", i, data_log[i], exp_word(12'h010, 4, i));
      end
    end
    n_checks++;
    if (done_cnt != 1 || busy_at_done != 0) begin
      n_fail++; $display("FAIL basic_done: pulses %0d busy_at_done %0d want 1/0", done_cnt, busy_at_done);
    end
  endtask

  task automatic test_backpressure();
    bit ok;
    lat_min = 1; lat_max = 2; wait_pct = 0; ready_pct = 100;
    clear_logs();
    force_ready0 = 1'b1;
    pulse_start(12'h200, 11'd20);
    tick(30);
    n_checks++;
    if (addr_log.size() != DEPTH || data_log.size() != 0 || avm_read !== 1'b0) begin
      n_fail++; $display("FAIL bp_stall: reqs %0d words %0d read %b want 8/0/0", addr_log.size(), data_log.size(), avm_read);
    end
    force_ready0 = 1'b0;
    wait_done(500, ok);
    n_checks++;
    if (!ok || data_log.size() != 20 || addr_log.size() != 20) begin
      n_fail++; $display("FAIL bp_count: done %b reqs %0d words %0d want 1/20/20", ok, addr_log.size(), data_log.size());
    end
    for (int i = 0; i < data_log.size(); i++) begin
      n_checks++;
      if (data_log[i] !== exp_word(12'h200, 20, i)) begin
        n_fail++; $display("FAIL bp_word[%0d]: got %h want %h", i, data_log[i], exp_word(12'h200, 20, i));
      end
    end
    n_checks++;
    if (max_credit > DEPTH) begin n_fail++; $display("FAIL bp_credit: in-flight %0d limit %0d", max_credit, DEPTH); end
  endtask

  task automatic test_wrap();
    bit ok;
    logic [11:0] want [4];
    want[0] = 12'hFF8; want[1] = 12'hFFC; want[2] = 12'h000; want[3] = 12'h004;
    lat_min = 1; lat_max = 3; wait_pct = 0; ready_pct = 100;
    clear_logs();
    pulse_start(12'hFFA, 11'd4);
    wait_done(100, ok);
    n_checks++;
    if (!ok || addr_log.size() != 4 || data_log.size() != 4) begin
      n_fail++; $display("FAIL wrap_count: done %b reqs %0d words %0d want 1/4/4", ok, addr_log.size(), data_log.size());
    end
    for (int i = 0; i < addr_log.size() && i < 4; i++) begin
      n_checks++;
      if (addr_log[i] !== want[i]) begin n_fail++; $display("FAIL wrap_addr[%0d]: got %h want %h", i, addr_log[i], want[i]); end
    end
    for (int i = 0; i < data_log.size(); i++) begin
      n_checks++;
      if (data_log[i] !== exp_word(12'hFF8, 4, i)) begin
        n_fail++; $display("FAIL wrap_word[%0d]: got %h want %h", i, data_log[i], exp_word(12'hFF8, 4, i));
      end
    end
  endtask

  task automatic test_waitrequest();
    bit ok;
    lat_min = 1; lat_max = 1; wait_pct = 0; ready_pct = 100;
    clear_logs();
    stall_idx = 1; stall_left = 3;
    pulse_start(12'h000, 11'd4);
    wait_done(100, ok);
    stall_left = 0; stall_idx = -1;
    n_checks++;
    if (stall_log.size() != 3) begin n_fail++; $display("FAIL wait_len: stalled cycles %0d want 3", stall_log.size()); end
    for (int i = 0; i < stall_log.size(); i++) begin
      n_checks++;
      if (stall_log[i] !== 12'h004) begin n_fail++; $display("FAIL wait_addr[%0d]: got %h want 004", i, stall_log[i]); end
    end
    n_checks++;
    if (!ok || addr_log.size() != 4 || data_log.size() != 4) begin
      n_fail++; $display("FAIL wait_count: done %b reqs %0d words %0d want 1/4/4", ok, addr_log.size(), data_log.size());
    end
    for (int i = 0; i < data_log.size(); i++) begin
      n_checks++;
      if (data_log[i] !== exp_word(12'h000, 4, i) || addr_log[i] !== exp_addr(12'h000, i)) begin
        n_fail++; $display("FAIL wait_word[%0d]: got %h @%h want %h @%h", i, data_log[i], addr_log[i], exp_word(12'h000, 4, i), exp_addr(12'h000, i));
      end
    end
  endtask

  task automatic test_zero_length();
    clear_logs();
    inject_rdv = 1'b1;
    tick(2);
    n_checks++;
    if (st_valid !== 1'b0) begin n_fail++; $display("FAIL idle_rdv: st_valid %b want 0", st_valid); end
    pulse_start(12'h123, 11'd0);
    tick(4);
    n_checks++;
    if (done_cnt != 1 || busy_cnt != 0 || read_cnt != 0) begin
      n_fail++; $display("FAIL zero_len: done cycles %0d busy cycles %0d reads %0d want 1/0/0", done_cnt, busy_cnt, read_cnt);
    end
  endtask

  task automatic test_start_ignored();
    bit ok;
    lat_min = 1; lat_max = 2; wait_pct = 0; ready_pct = 50;
    clear_logs();
    pulse_start(12'h300, 11'd6);
    tick(3);
    n_checks++;
    if (busy !== 1'b1) begin n_fail++; $display("FAIL ign_busy: got %b want 1", busy); end
    pulse_start(12'h7F0, 11'd3);
    wait_done(300, ok);
    n_checks++;
    if (!ok || done_cnt != 1 || addr_log.size() != 6 || data_log.size() != 6) begin
      n_fail++; $display("FAIL ign_count: done %0d reqs %0d words %0d want 1/6/6", done_cnt, addr_log.size(), data_log.size());
    end
    for (int i = 0; i < data_log.size(); i++) begin
      n_checks++;
      if (data_log[i] !== exp_word(12'h300, 6, i) || addr_log[i] !== exp_addr(12'h300, i)) begin
        n_fail++; $display("FAIL ign_word[%0d]: got %h @%h want %h @%h", i, data_log[i], addr_log[i], exp_word(12'h300, 6, i), exp_addr(12'h300, i));
      end
    end
  endtask

  task automatic test_reset_mid();
    bit ok;
    int n;
    lat_min = 1; lat_max = 1; wait_pct = 0; ready_pct = 100;
    clear_logs();
    pulse_start(12'h100, 11'd8);
    n = 0;
    while (data_log.size() < 2 && n < 50) begin tick(1); n++; end
    force_ready0 = 1'b1;
    tick(1);
    reset_n = 1'b0;
    #1;
    n_checks++;
    if ({busy, done, avm_read, st_valid, st_sop, st_eop} !== 6'b0 || avm_address !== 12'h0 || st_data !== 32'h0) begin
      n_fail++; $display("FAIL rst_mid_out: ctrl %b addr %h data %h want 0", {busy, done, avm_read, st_valid, st_sop, st_eop}, avm_address, st_data);
    end
    rq.delete();
    tick(2);
    reset_n = 1'b1;
    force_ready0 = 1'b0;
    tick(10);
    n_checks++;
    if (done_cnt != 0 || data_log.size() != 2 || busy !== 1'b0) begin
      n_fail++; $display("FAIL rst_mid_abort: done %0d words %0d busy %b want 0/2/0", done_cnt, data_log.size(), busy);
    end
    clear_logs();
    pulse_start(12'h040, 11'd1);
    wait_done(100, ok);
    n_checks++;
    if (!ok || data_log.size() != 1 || addr_log.size() != 1) begin
      n_fail++; $display("FAIL rst_new_count: done %b words %0d reqs %0d want 1/1/1", ok, data_log.size(), addr_log.size());
    end else begin
      n_checks++;
      if (data_log[0] !== exp_word(12'h040, 1, 0) || addr_log[0] !== 12'h040) begin
        n_fail++; $display("FAIL rst_new_word: got %h @%h want %h @040", data_log[0], addr_log[0], exp_word(12'h040, 1, 0));
      end
    end
  endtask

  task automatic test_random();
    bit ok;
    logic [11:0] b;
    int len;
    for (int t = 0; t < 13; t++) begin
      b = 12'($urandom);
      if (t == 12) begin
        len = 1024; lat_max = 3; wait_pct = 10; ready_pct = 90;
      end else begin
        len = int'($urandom_range(40, 1));
        lat_max = int'($urandom_range(5, 1));
        wait_pct = int'($urandom_range(50, 0));
        ready_pct = int'($urandom_range(100, 30));
      end
      lat_min = 1;
      clear_logs();
      pulse_start(b, 11'(len));
      wait_done(8000, ok);
      n_checks++;
      if (!ok || done_cnt != 1 || busy_at_done != 0 || addr_log.size() != len || data_log.size() != len) begin
        n_fail++; $display("FAIL rand%0d_count: done %0d busy_at_done %0d reqs %0d words %0d want 1/0/%0d/%0d", t, done_cnt, busy_at_done, addr_log.size(), data_log.size(), len, len);
      end
      n_checks++;
      if (max_credit > DEPTH) begin n_fail++; $display("FAIL rand%0d_credit: in-flight %0d limit %0d", t, max_credit, DEPTH); end
      for (int i = 0; i < data_log.size() && i < addr_log.size(); i++) begin
        n_checks++;
        if (data_log[i] !== exp_word(b, len, i) || addr_log[i] !== exp_addr(b, i)) begin
          n_fail++; $display("FAIL rand%0d_word[%0d]: got %h @%h want %h @%h", t, i, data_log[i], addr_log[i], exp_word(b, len, i), exp_addr(b, i));
        end
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) mem_model[i] = $urandom;
    test_reset();
    test_basic();
    test_backpressure();
    test_wrap();
    test_waitrequest();
    test_zero_length();
    test_start_ignored();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation exceeded time limit at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/onchip_mem_reader.md
ONCHIP_MEM_READER -- requirements
Module: onchip_mem_reader

Interface
REQ-001 Parameter ADDR_W, default 12, byte-address width of the Avalon-MM master port.
REQ-002 Parameter FIFO_DEPTH, default 8, output buffer depth in 32-bit words, power of two, 2 to 32.
REQ-003 clk  input  1  single clock for all logic.
REQ-004 reset_n  input  1  asynchronous, active-low reset.
REQ-005 start  input  1  one-cycle command strobe, sampled only in IDLE.
REQ-006 base_addr  input  ADDR_W  start byte address, bits [1:0] ignored and treated as 0.
REQ-007 length  input  11  number of 32-bit words to read, 0 to 1024.
REQ-008 busy  output  1  high from the cycle after an accepted start until the cycle done is asserted.
REQ-009 done  output  1  one-cycle pulse when the final word is accepted downstream.
REQ-010 avm_address  output  ADDR_W  Avalon-MM read byte address, word aligned.
REQ-011 avm_read  output  1  Avalon-MM read request.
REQ-012 avm_waitrequest  input  1  slave stall, request held while high.
REQ-013 avm_readdata  input  32  read data.
REQ-014 avm_readdatavalid  input  1  qualifies avm_readdata, responses in request order.
REQ-015 st_data  output  32  Avalon-ST source data.
REQ-016 st_valid  output  1  source valid.
REQ-017 st_ready  input  1  sink ready, zero ready-latency.
REQ-018 st_sop / st_eop  output  1 each  first / last word of the transfer.

Function
REQ-019 States: IDLE, ISSUE, DRAIN. IDLE->ISSUE on start with length>0. ISSUE->DRAIN when the length-th request is accepted. DRAIN->IDLE when the last word transfers on st.
REQ-020 A start with length==0 in IDLE causes no bus activity: done pulses the next cycle, busy stays low.
REQ-021 A start while busy is ignored, with no change to the transfer in progress.
REQ-022 A request is accepted in a cycle with avm_read=1 and avm_waitrequest=0. avm_address and avm_read are held stable while waitrequest is high.
REQ-023 The first request address is base_addr with bits [1:0]=0. Each accepted request increments the address by 4, wrapping modulo 2^ADDR_W.
REQ-024 avm_read asserts only when (fifo_count + outstanding) < FIFO_DEPTH, so every response always has a buffer slot. The FIFO shall never overflow.
REQ-025 Outstanding counter: +1 on request acceptance, -1 on readdatavalid, both in the same cycle leave it unchanged. Width is log2(FIFO_DEPTH)+1 bits.
REQ-026 Each readdatavalid word is written into the FIFO in the same cycle. Data appears on st_data no earlier than the next cycle.
REQ-027 st_valid = FIFO not empty. A word transfers when st_valid & st_ready. st_data/sop/eop are held stable while st_valid & ~st_ready.
REQ-028 st_sop marks word index 0 and st_eop marks word index length-1. Both are high for length==1.
REQ-029 Simultaneous FIFO write and read when full or empty shall be handled without loss or duplication.
REQ-030 Back-to-back requests, one per cycle, shall be sustained while credit is available and waitrequest is low.
REQ-031 done rises in the same cycle as the eop transfer is registered, so done is high the cycle after the handshake, and busy falls in that same cycle.
REQ-032 A readdatavalid arriving in IDLE shall be ignored.

Reset
REQ-033 While reset_n is low, asynchronously: state=IDLE; busy, done, avm_read, st_valid, st_sop, st_eop=0; avm_address=0; FIFO and counters cleared; st_data=0.
REQ-034 Reset asserted mid-transfer shall abort it with no done pulse. After release the block waits in IDLE for a new start.

Verification
REQ-035 base_addr=0x010, length=4, waitrequest=0, 1-cycle read latency, st_ready=1 -> addresses 0x010/0x014/0x018/0x01C on consecutive cycles, 4 words in order, sop on word 0, eop on word 3, one done pulse.
REQ-036 length=20, st_ready=0 for 30 cycles then 1 -> avm_read stops after 8 issued reads (FIFO_DEPTH=8), no data lost, all 20 words delivered in order.
REQ-037 base_addr=0xFF8, length=4 -> addresses 0xFF8, 0xFFC, 0x000, 0x004.
REQ-038 waitrequest held high 3 cycles on the second request -> avm_address stays 0x004 (base 0) and avm_read stays high throughout, with no skipped or duplicated word.
REQ-039 length=0 -> no avm_read, done high exactly one cycle, busy never high; a second start during an active transfer is ignored.
REQ-040 reset_n pulsed low after 2 of 8 words -> all outputs 0 immediately, no done pulse; a new start of length 1 then completes normally with sop=eop=1.
